// File: rtl/psram_ch_if.sv
`default_nettype none
// ============================================================================
// Module      : psram_ch_if
// Description : User-port bundle of one PSRAM controller channel
//               (command strobe, address, write beat, read beat, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface psram_ch_if #(
    parameter int ADDR_W = 21
) ();
    logic              cmd;
    logic              cmd_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic [3:0]        data_mask;
    logic [31:0]       rd_data;
    logic              rd_data_valid;
    logic              init_calib;
    logic              busy;
    logic              cmd_drop;

    // Memory front end side: issues commands, consumes read beats.
    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, init_calib, busy, cmd_drop
    );

    // Controller (or emulator) side.
    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, init_calib, busy, cmd_drop
    );
endinterface
`default_nettype wire

// File: rtl/psram_ch_emu.sv
`default_nettype none
// ============================================================================
// Module      : psram_ch_emu
// Description : Block-RAM backed stand-in for one PSRAM controller channel.
//               Emulates calibration delay, fixed bursts, fixed read latency
//               and byte-masked writes, cycle-exact at the user port.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_ch_emu #(
    parameter int ADDR_W      = 21,
    parameter int MEM_AW      = 16,
    parameter int BURST       = 4,
    parameter int RD_LAT      = 8,
    parameter int WR_CYC      = 12,
    parameter int INIT_CYCLES = 64
) (
    input  wire logic   clk_out,
    input  wire logic   rst_n,
    psram_ch_if.slave   bus
);
    localparam int DEPTH   = 1 << MEM_AW;
    localparam int CNT_MAX = (INIT_CYCLES > WR_CYC) ?
                             ((INIT_CYCLES > RD_LAT + BURST) ? INIT_CYCLES : RD_LAT + BURST) :
                             ((WR_CYC > RD_LAT + BURST) ? WR_CYC : RD_LAT + BURST);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_PRE    = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] RD_FIRST  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] RD_END    = CNT_W'(RD_LAT + BURST - 1);
    localparam logic [CNT_W-1:0] BURST_C   = CNT_W'(BURST);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WRITE    = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_BURST = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;          // cycles since reset (INIT) or since cmd edge
    logic [MEM_AW-1:0]  addr_r;               // start halfword of the current command
    logic               drop_nx, init_set, addr_ld, rd_cap;
    logic               mem_we;
    logic [MEM_AW-1:0]  mem_wa, mem_wa1, rd_a, rd_a1;
    logic               init_calib_r, rd_valid_r, cmd_drop_r;
    logic [31:0]        rd_data_r;

    // Halfword storage split into high/low byte lanes so each byte has its own enable.
    logic [7:0] mem_hi [0:DEPTH-1];
    logic [7:0] mem_lo [0:DEPTH-1];

    // Address bits above the backing store depth are ignored (aliasing is intended).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:MEM_AW];

    // Beat k of a command sits at start + 2k; cnt equals k during a write and
    // RD_LAT + k during the read burst.
    assign mem_wa1 = mem_wa + MEM_AW'(1);
    assign rd_a    = addr_r + MEM_AW'({cnt - RD_FIRST, 1'b0});
    assign rd_a1   = rd_a + MEM_AW'(1);

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        drop_nx  = 1'b0;
        init_set = 1'b0;
        addr_ld  = 1'b0;
        rd_cap   = 1'b0;
        mem_we   = 1'b0;
        mem_wa   = addr_r + MEM_AW'({cnt, 1'b0});
        case (state)
            S_INIT: begin
                drop_nx = bus.cmd_en;
                if (cnt == INIT_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    init_set = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_nx = '0;
                if (bus.cmd_en) begin
                    addr_ld = 1'b1;
                    cnt_nx  = CNT_W'(1);
                    if (bus.cmd) begin
                        // Beat 0 commits on the command edge itself.
                        mem_we   = 1'b1;
                        mem_wa   = bus.addr[MEM_AW-1:0];
                        state_nx = S_WRITE;
                    end else begin
                        state_nx = S_RD_WAIT;
                    end
                end
            end
            S_WRITE: begin
                drop_nx = bus.cmd_en;
                mem_we  = (cnt < BURST_C);
                if (cnt == WR_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            S_RD_WAIT: begin
                drop_nx = bus.cmd_en;
                if (cnt == RD_PRE) begin
                    state_nx = S_RD_BURST;
                end
            end
            S_RD_BURST: begin
                // Going idle on the last beat edge lets the next command land
                // on the edge that retires rd_data_valid.
                drop_nx = bus.cmd_en;
                rd_cap  = 1'b1;
                if (cnt == RD_END) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_INIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Control and output registers; reset aborts any command in flight.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            cnt          <= '0;
            addr_r       <= '0;
            init_calib_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= '0;
            cmd_drop_r   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cmd_drop_r <= drop_nx;
            rd_valid_r <= rd_cap;
            if (addr_ld)  addr_r       <= bus.addr[MEM_AW-1:0];
            if (init_set) init_calib_r <= 1'b1;
            if (rd_cap)   rd_data_r    <= {mem_hi[rd_a], mem_lo[rd_a], mem_hi[rd_a1], mem_lo[rd_a1]};
        end
    end

    // Byte-masked store; contents deliberately survive reset.
    always_ff @(posedge clk_out) begin
        if (mem_we) begin
            if (!bus.data_mask[3]) mem_hi[mem_wa]  <= bus.wr_data[31:24];
            if (!bus.data_mask[2]) mem_lo[mem_wa]  <= bus.wr_data[23:16];
            if (!bus.data_mask[1]) mem_hi[mem_wa1] <= bus.wr_data[15:8];
            if (!bus.data_mask[0]) mem_lo[mem_wa1] <= bus.wr_data[7:0];
        end
    end

    assign bus.init_calib    = init_calib_r;
    assign bus.rd_data       = rd_data_r;
    assign bus.rd_data_valid = rd_valid_r;
    assign bus.cmd_drop      = cmd_drop_r;
    assign bus.busy          = (state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_psram_ch_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_psram_ch_emu
// Description : Scoreboard bench for psram_ch_emu with a byte-level memory
//               model, directed timing scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_ch_emu;
    localparam int ADDR_W      = 21;
    localparam int MEM_AW      = 16;
    localparam int BURST       = 4;
    localparam int RD_LAT      = 8;
    localparam int WR_CYC      = 12;
    localparam int INIT_CYCLES = 64;
    localparam int DEPTH       = 1 << MEM_AW;

    logic clk_out = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_out = ~clk_out;

    psram_ch_if #(.ADDR_W(ADDR_W)) bus ();

    psram_ch_emu #(
        .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BURST(BURST), .RD_LAT(RD_LAT),
        .WR_CYC(WR_CYC), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] exp;
        logic [31:0] km;   // bytes the model knows; unknown bytes are not compared
    } beat_t;

    beat_t       sbq [$];
    logic [7:0]  mdl [int];   // byte index = halfword*2 + (0 high, 1 low)
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_valid_cyc = -1;
    int          valid_beats = 0;

    // Free-running cycle count, updated on every active edge.
    initial forever begin
        @(posedge clk_out);
        cyc++;
    end

    // Monitor: every read beat the DUT presents is matched against the scoreboard.
    initial begin
        logic  prev_valid;
        beat_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_out);
            if (bus.rd_data_valid === 1'b1) begin
                if (!prev_valid) first_valid_cyc = cyc;
                valid_beats++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: rd_data_valid with data %h, expected no beat", bus.rd_data);
                end else begin
                    e = sbq.pop_front();
                    if (((bus.rd_data ^ e.exp) & e.km) != 32'h0) begin
                        errors++;
                        $display("FAIL rd_beat: got %h expected %h (known bytes %h)", bus.rd_data, e.exp, e.km);
                    end
                end
            end
            prev_valid = (bus.rd_data_valid === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic int hw(input int a);
        return a & (DEPTH - 1);
    endfunction

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_write(input int a, input int k, input logic [31:0] d, input logic [3:0] m);
        int h, bi;
        h = hw(a + 2 * k);
        for (int b = 0; b < 4; b++) begin
            bi = hw(h + b / 2) * 2 + (b % 2);
            if (!m[3 - b]) mdl[bi] = d[31 - 8 * b -: 8];
        end
    endtask

    task automatic push_read(input int a);
        beat_t e;
        int    h, bi;
        for (int k = 0; k < BURST; k++) begin
            e.exp = '0;
            e.km  = '0;
            h = hw(a + 2 * k);
            for (int b = 0; b < 4; b++) begin
                bi = hw(h + b / 2) * 2 + (b % 2);
                if (mdl.exists(bi)) begin
                    e.exp[31 - 8 * b -: 8] = mdl[bi];
                    e.km[31 - 8 * b -: 8]  = 8'hFF;
                end
            end
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy %b after %0d cycles, expected 0", bus.busy, n);
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (bus.init_calib !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (bus.init_calib !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_init: init_calib %b after %0d cycles, expected 1", bus.init_calib, n);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.rd_data_valid === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_drain: %0d beats outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_write(input int a, input logic [127:0] d, input logic [15:0] m);
        wait_idle();
        bus.cmd    = 1'b1;
        bus.cmd_en = 1'b1;
        bus.addr   = ADDR_W'(a);
        for (int k = 0; k < BURST; k++) begin
            bus.wr_data   = d[127 - 32 * k -: 32];
            bus.data_mask = m[15 - 4 * k -: 4];
            tick();
            bus.cmd_en = 1'b0;
            model_write(a, k, d[127 - 32 * k -: 32], m[15 - 4 * k -: 4]);
        end
        bus.data_mask = 4'hF;
    endtask

    // Returns at #1 after the command edge; t0 is that edge's cycle number.
    task automatic do_read(input int a, output int t0);
        wait_idle();
        push_read(a);
        bus.cmd    = 1'b0;
        bus.cmd_en = 1'b1;
        bus.addr   = ADDR_W'(a);
        tick();
        t0 = cyc;
        bus.cmd_en = 1'b0;
    endtask

    initial begin
        int          t0, t1;
        logic [31:0] fb [4];
        logic [127:0] p, q;

        fb[0] = 32'h11112222; fb[1] = 32'h33334444; fb[2] = 32'h55556666; fb[3] = 32'h77778888;
        bus.cmd = 1'b0; bus.cmd_en = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.data_mask = 4'hF;

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_init_calib", 32'(bus.init_calib), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd1);
        check("reset_valid", 32'(bus.rd_data_valid), 32'd0);
        check("reset_drop", 32'(bus.cmd_drop), 32'd0);
        check("reset_rd_data", bus.rd_data, 32'd0);
        rst_n = 1'b1;
        wait_init();
        do_write(32'h380, 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4, 16'h0000);
        wait_idle();

        // Second reset: exact INIT length, command dropped during INIT
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 1; i <= INIT_CYCLES; i++) begin
            bus.cmd_en = (i == 10); bus.cmd = 1'b1; bus.addr = ADDR_W'(32'h380);
            bus.wr_data = 32'hDEADBEEF; bus.data_mask = 4'h0;
            tick();
            if (i == 10) check("init_drop", 32'(bus.cmd_drop), 32'd1);
            if (i == 11) check("init_drop_clear", 32'(bus.cmd_drop), 32'd0);
            if (i == INIT_CYCLES - 1) check("init_calib_early", 32'(bus.init_calib), 32'd0);
            if (i == INIT_CYCLES) check("init_calib_edge", 32'(bus.init_calib), 32'd1);
        end
        bus.cmd_en = 1'b0; bus.cmd = 1'b0; bus.data_mask = 4'hF;
        check("init_busy_low", 32'(bus.busy), 32'd0);
        do_read(32'h380, t0);       // persistence over reset, dropped write ineffective
        wait_drain();

        // Halfword write with partial mask, latency and burst length
        do_write(32'h100, {32'h12345678, 96'h0}, 16'h3FFF);
        valid_beats = 0;
        do_read(32'h100, t0);
        wait_drain();
        check("rd_latency", 32'(first_valid_cyc - t0), 32'(RD_LAT));
        check("rd_valid_len", 32'(valid_beats), 32'(BURST));

        // Byte lanes of one halfword
        do_write(32'h200, {32'h00AB0000, 96'h0}, 16'hBFFF);
        do_write(32'h200, {32'hCD000000, 96'h0}, 16'h7FFF);
        do_read(32'h200, t0);
        repeat (RD_LAT) tick();
        check("byte_merge", {16'h0, bus.rd_data[31:16]}, 32'h0000CDAB);
        wait_drain();

        // Full burst across the top of memory
        do_write(DEPTH - 2, {fb[0], fb[1], fb[2], fb[3]}, 16'h0000);
        do_read(0, t0);
        repeat (RD_LAT) tick();
        check("wrap_read_addr0", bus.rd_data, fb[1]);
        wait_drain();
        do_read(DEPTH - 2, t0);
        repeat (RD_LAT) tick();
        for (int k = 0; k < BURST; k++) begin
            check("wrap_burst_beat", bus.rd_data, fb[k]);
            tick();
        end
        tick();
        check("rd_hold_data", bus.rd_data, fb[3]);
        check("rd_hold_valid", 32'(bus.rd_data_valid), 32'd0);

        // Back-to-back: drop during read, next read accepted at T0+12
        do_write(32'h300, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h0000);
        do_read(32'h100, t0);
        repeat (4) tick();
        bus.cmd = 1'b1; bus.cmd_en = 1'b1; bus.addr = ADDR_W'(32'h300);
        bus.wr_data = 32'hFFFFFFFF; bus.data_mask = 4'h0;
        tick();
        bus.cmd_en = 1'b0; bus.data_mask = 4'hF;
        check("b2b_drop", 32'(bus.cmd_drop), 32'd1);
        repeat (6) tick();
        check("b2b_busy_low", 32'(bus.busy), 32'd0);
        do_read(32'h300, t1);
        check("b2b_accept", 32'(t1 - t0), 32'(RD_LAT + BURST));
        wait_drain();
        check("b2b_first_valid", 32'(first_valid_cyc - t0), 32'(RD_LAT + BURST + RD_LAT));

        // Reset one cycle into a write: only beat 0 survives
        p = {$urandom, $urandom, $urandom, $urandom};
        q = {$urandom, $urandom, $urandom, $urandom};
        do_write(32'h400, p, 16'h0000);
        wait_idle();
        bus.cmd = 1'b1; bus.cmd_en = 1'b1; bus.addr = ADDR_W'(32'h400);
        bus.wr_data = q[127:96]; bus.data_mask = 4'h0;
        tick();
        model_write(32'h400, 0, q[127:96], 4'h0);
        bus.cmd_en = 1'b0; bus.wr_data = q[95:64];
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        bus.data_mask = 4'hF;
        for (int i = 0; i < INIT_CYCLES && bus.init_calib !== 1'b1; i++) begin
            check("init_no_valid", 32'(bus.rd_data_valid), 32'd0);
            tick();
        end
        wait_init();
        do_read(32'h400, t0);
        repeat (RD_LAT) tick();
        check("abort_beat0", bus.rd_data, q[127:96]);
        tick();
        check("abort_beat1", bus.rd_data, p[95:64]);
        wait_drain();

        // Random traffic over a pre-filled window
        for (int j = 0; j < 16; j++)
            do_write(32'h500 + 8 * j, {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
        for (int j = 0; j < 60; j++) begin
            int a;
            a = (($urandom_range(0, 7) == 0) ? (DEPTH - 4) : 32'h500) + $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1)
                do_write(a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            else
                do_read(a, t0);
        end
        wait_idle();
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/psram_ch_emu.md
# psram_ch_emu

Cycle-level responder for one channel of the PSRAM controller user port (cmd / cmd_en / addr / wr_data / data_mask / rd_data / rd_data_valid / init_calib). It is backed by on-chip block RAM. It stands in for the PSRAM controller channel in simulation and on boards without PSRAM, so the DCJ11 memory front end runs unmodified against it. It reproduces the controller's calibration delay, fixed-length bursts, fixed read latency and masked byte writes.

## Interface
Parameters:
- ADDR_W, 21: width of `addr`, in 16-bit halfword units.
- MEM_AW, 16: log2 of backing-store depth in halfwords (128 KB default). Only `addr[MEM_AW-1:0]` is used.
- BURST, 4: 32-bit beats per command. Legal values are 2, 4 and 8.
- RD_LAT, 8: cycles from the cmd_en edge to the first read beat. Must be ≥2.
- WR_CYC, 12: cycles from the write cmd_en edge until a new command is accepted. Must be ≥BURST.
- INIT_CYCLES, 64: cycles after reset release before init_calib asserts.

Ports:
- clk_out  in  1  Single clock domain; all ports are sampled or driven on posedge clk_out.
- rst_n  in  1  Reset: asynchronous, active-low.
- init_calib  out  1  High once emulated calibration is done.
- cmd  in  1  Command type: 0 = read, 1 = write.
- cmd_en  in  1  Single-cycle command strobe.
- addr  in  ADDR_W  Start halfword address.
- wr_data  in  32  Write beat data. [31:16] is halfword addr+2k; [15:0] is halfword addr+2k+1.
- data_mask  in  4  Per-byte write mask, 1 = do not write. Bit3→[31:24], bit2→[23:16], bit1→[15:8], bit0→[7:0].
- rd_data  out  32  Read beat data, same layout as wr_data.
- rd_data_valid  out  1  High for each read beat.
- busy  out  1  High while a command is in progress or during INIT.
- cmd_drop  out  1  One-cycle pulse when a cmd_en is ignored.

## Operation
- Byte order within a halfword: the high byte sits in the odd mask bit (bit3, bit1); the low byte sits in the even bit (bit2, bit0).
- Storage: 2^MEM_AW halfwords, each with a per-byte write enable.
  - Beat k covers halfwords (addr+2k) and (addr+2k+1), taken modulo 2^MEM_AW.
  - Addresses wrap silently.
  - Contents are not cleared by reset.
- State machine states: INIT, IDLE, WRITE, RD_WAIT, RD_BURST. A shared cycle counter `cnt` runs in every state.
- INIT:
  - Entered on reset; cnt counts up.
  - At cnt = INIT_CYCLES-1, go to IDLE; init_calib rises on that edge and stays high until the next reset.
- IDLE:
  - cmd_en with cmd = 1 → write beat 0 (wr_data, data_mask) is committed on the same edge; go to WRITE.
  - cmd_en with cmd = 0 → latch addr; go to RD_WAIT.
- WRITE:
  - Beats 1..BURST-1 are committed on the next BURST-1 edges, each with the data_mask presented that cycle.
  - Beat 1 uses addr+2.
  - Return to IDLE WR_CYC cycles after the cmd edge.
- RD_WAIT: wait until RD_LAT cycles after the cmd edge, then go to RD_BURST.
- RD_BURST:
  - Drive BURST consecutive beats with rd_data_valid = 1.
  - Then go to IDLE with rd_data_valid = 0.
  - rd_data holds the last beat until the next read.
- cmd_drop pulses for one cycle on any cmd_en seen outside IDLE, including during INIT. A dropped command has no other effect.
- A masked byte (mask bit = 1) leaves memory unchanged. A mask of 4'b1111 writes nothing.

## Timing
- T0 is the edge on which cmd_en is sampled in IDLE.
- Write:
  - Beat k commits at edge T0+k.
  - busy is high from T0 through T0+WR_CYC-1.
  - The next command is accepted at T0+WR_CYC.
- Read:
  - Beat k is registered at edge T0+RD_LAT+k and reads memory as of that edge.
  - rd_data_valid is high for cycles RD_LAT..RD_LAT+BURST-1.
  - The next command is accepted at T0+RD_LAT+BURST.
- Read after write: a read accepted after the write completes sees all committed beats.
- Reset values: init_calib = 0, rd_data = 0, rd_data_valid = 0, busy = 1, cmd_drop = 0, state = INIT, cnt = 0.
- Reset mid-command: the command aborts immediately.
  - Write beats already committed stay in memory; later beats are lost.
  - The INIT delay restarts on reset release.
- With the defaults, the first command is accepted at cycle INIT_CYCLES after release, i.e. cmd_en sampled on the 65th edge.

## Test plan
- Reset, then hold cmd_en = 0 → init_calib rises exactly 64 cycles after rst_n release. cmd_en at cycle 10 → cmd_drop pulses and memory is unchanged.
- Write addr = 0x100 with beat 0 = 0x1234_xxxx and mask 4'b0011, beats 1..3 with mask 4'b1111. Then read 0x100 → at T0+8, rd_data[31:16] = 0x1234; valid is high for exactly 4 cycles.
- Byte writes: write 0x00AB with mask 4'b1011, then 0xCD00 with mask 4'b0111, both to addr 0x200 → read returns [31:16] = 0xCDAB.
- Full burst: write beats 0x11112222, 0x33334444, 0x55556666, 0x77778888 with all masks 0, at addr = 2^16−2 → read addr 0 returns 0x33334444 on beat 0 (wrap-around); read 2^16−2 returns all 4 beats in order.
- Back-to-back commands: cmd_en at T0 (read) and at T0+5 → cmd_drop at T0+5. A second read at T0+12 is accepted, with first valid at T0+20.
- Reset asserted at write T0+1 (after beat 0) → after re-init, a read shows beat 0 written and beats 1..3 holding their old contents; rd_data_valid stays 0 through INIT.
